load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Sits between the execute stage and data_mem. Turns CPU byte-addressed
//   loads and stores into word accesses on data_mem's port. Handles
//   byte/half/word sizing, little-endian lane select, sign/zero extension,
//   and read-modify-write for sub-word stores.
//   Single outstanding request, driven by a valid/ready request handshake
//   and a one-cycle response pulse.
// PARAMETERS
//   ADDR_W  11  data_mem word-address width; word index = req_addr[ADDR_W+1:2]
//   XLEN    32  data width of the request, response and memory ports
// PORTS
//   clk           in   1       clock, rising edge
//   rst_n         in   1       reset, asynchronous assert, active-low
//   req_valid     in   1       request present
//   req_ready     out  1       LSU can accept a request (high only in IDLE)
//   req_we        in   1       1 = store, 0 = load
//   req_size      in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   req_unsigned  in   1       load zero-extends when 1, sign-extends when 0
//   req_addr      in   XLEN    byte address
//   req_wdata     in   XLEN    store data, right-aligned
//   resp_valid    out  1       one-cycle completion pulse
//   resp_rdata    out  XLEN    extended load data; 0 for stores
//   resp_err      out  1       misaligned access (see CONFIGURATION)
//   mem_write     out  1       to data_mem.mem_write
//   mem_addr      out  ADDR_W  to data_mem.addr
//   mem_wdata     out  XLEN    to data_mem.wdata
//   mem_rdata     in   XLEN    from data_mem.rdata; valid in the same cycle as mem_addr
// BEHAVIOUR
//   Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//     resp_err=0, mem_write=0, mem_addr=0, mem_wdata=0.
//   Request is accepted when req_valid & req_ready at the clock edge.
//     All request fields are registered on acceptance.
//   FSM states: IDLE, READ, WRITE, RESP.
//     IDLE  -> READ   on accepted load or sub-word store
//     IDLE  -> WRITE  on accepted word store
//     READ  -> RESP   for a load; lane extracted from mem_rdata and registered
//     READ  -> WRITE  for a sub-word store; mem_rdata captured for the merge
//     WRITE -> RESP   mem_write=1 for exactly this one cycle, with merged data
//     RESP  -> IDLE   resp_valid=1 for one cycle; there is no backpressure
//   Latency, from acceptance edge to resp_valid: load 2, word store 2,
//     sub-word store 3 cycles. Next request accepted at the earliest one
//     cycle after RESP.
//   Lanes are little-endian:
//     byte lane = addr[1:0]; half lane = addr[1]
//     extracted value is extended to XLEN per req_unsigned
//   Store merge: only the target bytes are replaced; all other bytes keep
//     the value read in READ.
//   mem_addr holds the latched word index from READ through WRITE.
//     mem_write is 0 in every state except WRITE.
//   Address bits above ADDR_W+1 are ignored; the word index wraps at 2^ADDR_W.
//   Reset asserted mid-operation: FSM returns to IDLE immediately and
//     mem_write drops asynchronously. A store that has not yet reached
//     WRITE leaves memory unchanged.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     half access with addr[0]!=0, or word access with addr[1:0]!=0,
//     goes IDLE -> RESP with resp_err=1 and resp_rdata=0. mem_write is
//     never asserted for it.
//   MISALIGN_TRAP_EN undefined:
//     resp_err is tied to 0; addr[0] (half) or addr[1:0] (word) is
//     forced to 0 before use.
// STRUCTURE
//   lsu_pkg: state encoding, SZ_BYTE/SZ_HALF/SZ_WORD size constants.
//   Sub-module lsu_align (combinational):
//     extract(rdata, lane, size, unsigned) -> load value
//     merge(old, wdata, lane, size)        -> store word
//   FSM and registers stay in load_store_unit.
// TESTING
//   Setup: data_mem word 1 = 32'hDEADBEEF.
//   1. Load word @0x4 -> resp_rdata=32'hDEADBEEF, 2 cycles after accept;
//      mem_write stays 0 throughout.
//   2. Load byte @0x5 signed -> 32'hFFFFFFBE; same load unsigned -> 32'h000000BE.
//   3. Load half @0x6 signed -> 32'hFFFFDEAD.
//   4. Store byte 8'h12 @0x7, then load word @0x4 -> 32'h12ADBEEF;
//      mem_write pulses once, exactly 2 cycles after accept.
//   5. Store half 16'hCAFE @0x4 -> word 1 = 32'hDEADCAFE.
//      Assert rst_n=0 during READ of a second store -> word unchanged,
//      resp_valid=0, req_ready=1.
//   6. MISALIGN_TRAP_EN: word load @0x6 -> resp_err=1, resp_rdata=0,
//      1 cycle after accept. Without the macro the same load returns
//      32'hDEADCAFE with resp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(
    input logic [1:0] s
  );
    return s[1] ? SZ_WORD : s;
  endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// Little-endian lane extraction with sign/zero extension and
// sub-word store merging for the load/store unit.
module load_store_unit_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] store_word
);
  logic [4:0]      sh;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] mask;
  logic            sx;

  assign sh = {lane, 3'b000};

  always_comb begin
    shifted  = rdata >> sh;
    wsh      = wdata << sh;
    load_val = shifted;
    mask     = '1;
    sx       = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        sx       = ~is_unsigned & shifted[7];
        load_val = {{(XLEN-8){sx}}, shifted[7:0]};
        mask     = {{(XLEN-8){1'b0}}, 8'hFF} << sh;
      end
      (size == SZ_HALF): begin
        sx       = ~is_unsigned & shifted[15];
        load_val = {{(XLEN-16){sx}}, shifted[15:0]};
        mask     = {{(XLEN-16){1'b0}}, 16'hFFFF} << sh;
      end
      default: ;
    endcase
    // Bytes outside the target lane keep their previous value.
    store_word = (rdata & ~mask) | (wsh & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed CPU accesses onto a word memory.
// Optional misaligned-access trap enabled by MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);
  lsu_state_t      state;
  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      size_n;
  logic [1:0]      lane_n;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_word;
  logic            unused_addr;

  assign unused_addr = ^req_addr[XLEN-1:ADDR_W+2];
  assign size_n = norm_size(req_size);

  // Misaligned low bits are dropped before lane selection.
  always_comb begin
    lane_n = req_addr[1:0];
    unique case (1'b1)
      (size_n == SZ_HALF): lane_n = {req_addr[1], 1'b0};
      (size_n == SZ_WORD): lane_n = 2'b00;
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  logic misalign;
  assign misalign =
    (size_n == SZ_HALF && req_addr[0]) ||
    (size_n == SZ_WORD && req_addr[1:0] != 2'b00);
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  load_store_unit_align #(.XLEN(XLEN)) u_align (
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_val    (load_val),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      mem_write  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= size_n;
            lane_q    <= lane_n;
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[ADDR_W+1:2];
            req_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q     <= misalign;
            if (misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else
`endif
            if (req_we && size_n == SZ_WORD) begin
              state     <= WRITE;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= store_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_val;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          err_q     <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a
// behavioural word memory (combinational read, clocked write).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:2047];
  logic        poke = 1'b0;
  logic [10:0] poke_a = '0;
  logic [31:0] poke_d = '0;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(11), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    else if (poke) mem[poke_a] <= poke_d;
  end

  task automatic set_word(input logic [10:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    poke = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask

  task automatic do_req(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        err,
    output int          lat,
    output int          wr_cnt,
    output int          wr_cyc,
    output logic        rdy_after
  );
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 99; wr_cnt = 0; wr_cyc = 0;
    rd = 'x; err = 1'bx;
    for (int c = 1; c <= 8 && lat == 99; c++) begin
      if (mem_write) begin wr_cnt++; wr_cyc = c; end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; err = resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rdy_after = req_ready & ~resp_valid;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        ra;
  int          lt, wc, wy;

  task automatic test_reset();
    vec++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got %b want 1", req_ready); end
    vec++; if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got %b want 0", resp_valid); end
    vec++; if (resp_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
    vec++; if (resp_err !== 1'b0) begin
      bad++; $display("FAIL rst_err got %b want 0", resp_err); end
    vec++; if ({mem_write, mem_addr, mem_wdata} !== 44'h0) begin
      bad++; $display("FAIL rst_mem got %b/%h/%h want 0",
                      mem_write, mem_addr, mem_wdata); end
  endtask

  task automatic test_load_word();
    do_req(1'b0, 2'b10, 1'b0, 32'h4, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_data got %h want deadbeef", rd); end
    vec++; if (lt !== 2) begin
      bad++; $display("FAIL lw_lat got %0d want 2", lt); end
    vec++; if (wc !== 0) begin
      bad++; $display("FAIL lw_nowrite got %0d want 0", wc); end
    vec++; if (ra !== 1'b1) begin
      bad++; $display("FAIL lw_ready_after got %b want 1", ra); end
  endtask

  task automatic test_load_byte();
    do_req(1'b0, 2'b00, 1'b0, 32'h5, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hFFFFFFBE) begin
      bad++; $display("FAIL lb5_s got %h want ffffffbe", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h5, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'h000000BE) begin
      bad++; $display("FAIL lb5_u got %h want 000000be", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h4, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hFFFFFFEF) begin
      bad++; $display("FAIL lb4_s got %h want ffffffef", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h7, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'h000000DE) begin
      bad++; $display("FAIL lb7_u got %h want 000000de", rd); end
  endtask

  task automatic test_load_half();
    do_req(1'b0, 2'b01, 1'b0, 32'h6, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hFFFFDEAD) begin
      bad++; $display("FAIL lh6_s got %h want ffffdead", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h4, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'h0000BEEF) begin
      bad++; $display("FAIL lh4_u got %h want 0000beef", rd); end
  endtask

  task automatic test_store_byte();
    do_req(1'b1, 2'b00, 1'b0, 32'h7, 32'h12, rd, er, lt, wc, wy, ra);
    vec++; if (lt !== 3) begin
      bad++; $display("FAIL sb_lat got %0d want 3", lt); end
    vec++; if (wc !== 1 || wy !== 2) begin
      bad++; $display("FAIL sb_wpulse got %0d@%0d want 1@2", wc, wy); end
    vec++; if (rd !== 32'h0) begin
      bad++; $display("FAIL sb_rdata got %h want 0", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h4, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'h12ADBEEF) begin
      bad++; $display("FAIL sb_readback got %h want 12adbeef", rd); end
  endtask

  task automatic test_store_half_word();
    set_word(11'd1, 32'hDEADBEEF);
    do_req(1'b1, 2'b01, 1'b0, 32'h4, 32'h5555CAFE,
           rd, er, lt, wc, wy, ra);
    vec++; if (mem[1] !== 32'hDEADCAFE) begin
      bad++; $display("FAIL sh_mem got %h want deadcafe", mem[1]); end
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hA5A5A5A5,
           rd, er, lt, wc, wy, ra);
    vec++; if (lt !== 2 || wy !== 1 || wc !== 1) begin
      bad++; $display("FAIL sw_timing got lat%0d w%0d@%0d want lat2 w1@1",
                      lt, wc, wy); end
    vec++; if (mem[2] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL sw_mem got %h want a5a5a5a5", mem[2]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_addr = 32'h4; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vec++; if (mem_addr !== 11'd1) begin
      bad++; $display("FAIL mid_addr got %h want 1", mem_addr); end
    rst_n = 1'b0;
    #1;
    vec++; if ({mem_write, resp_valid, req_ready} !== 3'b001) begin
      bad++; $display("FAIL mid_rst got w%b v%b r%b want w0 v0 r1",
                      mem_write, resp_valid, req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (mem[1] !== 32'hDEADCAFE || resp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_mem got %h v%b want deadcafe v0",
                      mem[1], resp_valid); end
  endtask

  task automatic test_wrap_and_size();
    do_req(1'b0, 2'b10, 1'b0, 32'h8000_2004, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hDEADCAFE) begin
      bad++; $display("FAIL wrap got %h want deadcafe", rd); end
    do_req(1'b0, 2'b11, 1'b1, 32'h8, '0, rd, er, lt, wc, wy, ra);
    vec++; if (rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL rsvd_size got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 32'h6, '0, rd, er, lt, wc, wy, ra);
`ifdef MISALIGN_TRAP_EN
    vec++; if (er !== 1'b1 || rd !== 32'h0 || lt !== 1) begin
      bad++; $display("FAIL mis_lw got e%b %h lat%0d want e1 0 lat1",
                      er, rd, lt); end
    do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'hBEEF, rd, er, lt, wc, wy, ra);
    vec++; if (er !== 1'b1 || wc !== 0 || mem[1] !== 32'hDEADCAFE) begin
      bad++; $display("FAIL mis_sh got e%b w%0d %h want e1 w0 deadcafe",
                      er, wc, mem[1]); end
`else
    vec++; if (er !== 1'b0 || rd !== 32'hDEADCAFE || lt !== 2) begin
      bad++; $display("FAIL mis_lw got e%b %h lat%0d want e0 deadcafe lat2",
                      er, rd, lt); end
    do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'hBEEF, rd, er, lt, wc, wy, ra);
    vec++; if (er !== 1'b0 || wc !== 1 || mem[1] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL mis_sh got e%b w%0d %h want e0 w1 deadbeef",
                      er, wc, mem[1]); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[1] = 32'hDEADBEEF;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_load_word();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_store_half_word();
    test_reset_mid();
    test_wrap_and_size();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
